multiplier32_fp: RTL and testbench

Sequential IEEE-754 single-precision multiplier with a start/done handshake. It computes a_i × b_i over a fixed multi-cycle latency. It reports the special cases through dedicated flags: NaN, infinity, overflow and underflow. It sits as a coprocessor-style arithmetic unit behind a simple controller that pulses start and waits for done.

---
 rtl/multiplier32_fp_if.sv | 22 ++
 rtl/multiplier32_fp.sv | 199 +++++++++++++++++++
 tb/tb_multiplier32_fp.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier32_fp_if.sv
// Request/response bundle for the sequential binary32 multiplier.
interface multiplier32_fp_if;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] product_o;
    logic        done_o;
    logic        nan_o;
    logic        infinit_o;
    logic        overflow_o;
    logic        underflow_o;

    modport master (
        output start_i, a_i, b_i,
        input  product_o, done_o, nan_o, infinit_o, overflow_o, underflow_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output product_o, done_o, nan_o, infinit_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/multiplier32_fp.sv
// Sequential IEEE-754 binary32 multiplier: IDLE -> UNPACK -> MULT -> NORM,
// three cycles from the start edge to the done pulse. Subnormals are flushed
// and special cases are reported on dedicated, mutually exclusive flags.
module multiplier32_fp (
    input  logic             clk,
    input  logic             rst_n,
    multiplier32_fp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UNPACK, MULT, NORM} state_t;
    typedef enum logic [2:0] {CLS_NORMAL, CLS_NAN, CLS_INF, CLS_ZERO, CLS_SUB} cls_t;

    state_t state_q, state_d;

    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        ma_q, ma_d, mb_q, mb_d;
    cls_t               cls_q, cls_d;
    logic [47:0]        prod_q, prod_d;
    logic [31:0]        product_q, product_d;
    logic               done_q, done_d;
    logic               nan_q, nan_d, inf_q, inf_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;

    // Classification of the latched operands
    logic               a_nan, a_inf, a_zero, a_sub;
    logic               b_nan, b_inf, b_zero, b_sub;
    cls_t               cls_w;

    // Normalisation and rounding of the registered product
    logic [22:0]        mant_raw;
    logic               guard, rnd, sticky, round_up;
    logic [23:0]        mant_rnd;
    logic signed [9:0]  exp_n, exp_f;
    logic [22:0]        mant_f;

    assign bus.product_o   = product_q;
    assign bus.done_o      = done_q;
    assign bus.nan_o       = nan_q;
    assign bus.infinit_o   = inf_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = UNPACK;
            UNPACK:  state_d = MULT;
            MULT:    state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand classification; NaN (including inf x 0) wins over inf, inf over zero, zero over subnormal
    always_comb begin
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
        a_zero = (a_q[30:23] == 8'h00) && (a_q[22:0] == '0);
        a_sub  = (a_q[30:23] == 8'h00) && (a_q[22:0] != '0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
        b_zero = (b_q[30:23] == 8'h00) && (b_q[22:0] == '0);
        b_sub  = (b_q[30:23] == 8'h00) && (b_q[22:0] != '0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) cls_w = CLS_NAN;
        else if (a_inf || b_inf)                                      cls_w = CLS_INF;
        else if (a_zero || b_zero)                                    cls_w = CLS_ZERO;
        else if (a_sub || b_sub)                                      cls_w = CLS_SUB;
        else                                                          cls_w = CLS_NORMAL;
    end

    // Normalise by product bit 47, then round to nearest, ties to even
    always_comb begin
        if (prod_q[47]) begin
            mant_raw = prod_q[46:24];
            guard    = prod_q[23];
            rnd      = prod_q[22];
            sticky   = |prod_q[21:0];
            exp_n    = exp_q + 10'sd1;
        end else begin
            mant_raw = prod_q[45:23];
            guard    = prod_q[22];
            rnd      = prod_q[21];
            sticky   = |prod_q[20:0];
            exp_n    = exp_q;
        end
        round_up = guard && (rnd || sticky || mant_raw[0]);
        mant_rnd = {1'b0, mant_raw} + {23'd0, round_up};
        // A carry out of the rounded mantissa leaves its low 23 bits at zero
        exp_f    = mant_rnd[23] ? (exp_n + 10'sd1) : exp_n;
        mant_f   = mant_rnd[22:0];
    end

    // Datapath and output next values per state
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        cls_d     = cls_q;
        prod_d    = prod_q;
        product_d = product_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d = bus.a_i;
                    b_d = bus.b_i;
                end
            end
            UNPACK: begin
                sign_d = a_q[31] ^ b_q[31];
                exp_d  = signed'({2'b00, a_q[30:23]}) + signed'({2'b00, b_q[30:23]}) - 10'sd127;
                ma_d   = {1'b1, a_q[22:0]};
                mb_d   = {1'b1, b_q[22:0]};
                cls_d  = cls_w;
            end
            MULT: begin
                prod_d = 48'(ma_q) * 48'(mb_q);
            end
            NORM: begin
                done_d    = 1'b1;
                nan_d     = 1'b0;
                inf_d     = 1'b0;
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                product_d = '0;
                case (cls_q)
                    CLS_NAN:  nan_d = 1'b1;
                    CLS_INF: begin
                        product_d = {sign_q, 31'h7FFFFFFF};
                        inf_d     = 1'b1;
                    end
                    CLS_ZERO: product_d = '0;
                    CLS_SUB:  unf_d = 1'b1;
                    default: begin
                        if (exp_f >= 10'sd255) begin
                            product_d = {sign_q, 31'h7FFFFFFF};
                            ovf_d     = 1'b1;
                        end else if (exp_f <= 10'sd0) begin
                            unf_d = 1'b1;
                        end else begin
                            product_d = {sign_q, exp_f[7:0], mant_f};
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            cls_q     <= CLS_NORMAL;
            prod_q    <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            cls_q     <= cls_d;
            prod_q    <= prod_d;
            product_q <= product_d;
            done_q    <= done_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end
endmodule

// File: tb/tb_multiplier32_fp.sv
// Scoreboard bench for multiplier32_fp: expected results are queued when an
// operation is issued and popped when done_o is observed.
module tb_multiplier32_fp;
    logic clk = 1'b0;
    logic rst_n;

    multiplier32_fp_if bus ();

    multiplier32_fp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Flag vector order: {nan, infinit, overflow, underflow}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_NAN  = 4'b1000;
    localparam logic [3:0] F_INF  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    typedef struct {
        logic [31:0] p;
        logic [3:0]  f;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [3:0] flags_now();
        return {bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o};
    endfunction

    // Drive one start pulse, queue its expected result, then scramble the operands
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [3:0] f);
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        e.p = p;
        e.f = f;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
    endtask

    // Bounded wait for done_o, sampled 1ns after each rising edge
    task automatic wait_done(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        #3;
        n_checks++;
        if (bus.product_o !== 32'h0 || bus.done_o !== 1'b0 || flags_now() !== F_NONE) begin
            n_errors++;
            $display("FAIL reset_assert: product=%h done=%b flags=%b, need 00000000/0/0000",
                     bus.product_o, bus.done_o, flags_now());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.product_o !== 32'h0 || bus.done_o !== 1'b0 || flags_now() !== F_NONE) begin
            n_errors++;
            $display("FAIL reset_idle: product=%h done=%b flags=%b, need 00000000/0/0000",
                     bus.product_o, bus.done_o, flags_now());
        end
    endtask

    task automatic test_normal();
        vec_t vecs[$];
        exp_t e;
        bit   seen;
        int   lat;
        vecs.push_back('{"2.5x4",        32'h40200000, 32'h40800000, 32'h41200000, F_NONE});
        vecs.push_back('{"3.02x4",       32'h404147AE, 32'h40800000, 32'h414147AE, F_NONE});
        vecs.push_back('{"-1.5x2",       32'hBFC00000, 32'h40000000, 32'hC0400000, F_NONE});
        vecs.push_back('{"1x1",          32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE});
        vecs.push_back('{"tie_up_even",  32'h3FC00000, 32'h3F800001, 32'h3FC00002, F_NONE});
        vecs.push_back('{"tie_stay",     32'h3FC00000, 32'h3F800003, 32'h3FC00004, F_NONE});
        vecs.push_back('{"below_half",   32'h3FA00000, 32'h3F800001, 32'h3FA00001, F_NONE});
        vecs.push_back('{"round_carry",  32'h3FFFFFFF, 32'h3F800001, 32'h40000000, F_NONE});
        vecs.push_back('{"max_exp_ok",   32'h7F000000, 32'h3F800000, 32'h7F000000, F_NONE});
        vecs.push_back('{"min_exp_ok",   32'h00800000, 32'h3F800000, 32'h00800000, F_NONE});
        vecs.push_back('{"ovf_exp255",   32'h7F000000, 32'h40000000, 32'h7FFFFFFF, F_OVF});
        vecs.push_back('{"ovf_max_sq",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7FFFFFFF, F_OVF});
        vecs.push_back('{"ovf_neg",      32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFFFFFFFF, F_OVF});
        vecs.push_back('{"unf_exp0",     32'h00800000, 32'h3F000000, 32'h00000000, F_UNF});
        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].f);
            wait_done(seen, lat);
            n_checks++;
            if (!seen || lat != 3) begin
                n_errors++;
                $display("FAIL %s latency: seen=%0d cycles=%0d, need done after 3", vecs[i].name, seen, lat);
            end
            if (seen) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.product_o !== e.p || flags_now() !== e.f) begin
                    n_errors++;
                    $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                             e.name, bus.product_o, flags_now(), e.p, e.f);
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (bus.done_o !== 1'b0 || bus.product_o !== e.p || flags_now() !== e.f) begin
                    n_errors++;
                    $display("FAIL %s hold: done=%b product=%h flags=%b, need 0/%h/%b",
                             e.name, bus.done_o, bus.product_o, flags_now(), e.p, e.f);
                end
            end else begin
                sb.delete();
            end
        end
    endtask

    task automatic test_special();
        vec_t vecs[$];
        exp_t e;
        bit   seen;
        int   lat;
        vecs.push_back('{"zero_x4",      32'h00000000, 32'h40800000, 32'h00000000, F_NONE});
        vecs.push_back('{"negzero_x5",   32'h80000000, 32'h40A00000, 32'h00000000, F_NONE});
        vecs.push_back('{"1_x_nan",      32'h3F800000, 32'h7F800001, 32'h00000000, F_NAN});
        vecs.push_back('{"inf_x_0",      32'h7F800000, 32'h00000000, 32'h00000000, F_NAN});
        vecs.push_back('{"negzero_x_inf",32'h80000000, 32'h7F800000, 32'h00000000, F_NAN});
        vecs.push_back('{"qnan_x_0",     32'h7FC00000, 32'h00000000, 32'h00000000, F_NAN});
        vecs.push_back('{"inf_x_1",      32'h7F800000, 32'h3F800000, 32'h7FFFFFFF, F_INF});
        vecs.push_back('{"ninf_x_1",     32'hFF800000, 32'h3F800000, 32'hFFFFFFFF, F_INF});
        vecs.push_back('{"ninf_x_ninf",  32'hFF800000, 32'hFF800000, 32'h7FFFFFFF, F_INF});
        vecs.push_back('{"ninf_x_sub",   32'hFF800000, 32'h00000001, 32'hFFFFFFFF, F_INF});
        vecs.push_back('{"zero_x_sub",   32'h00000000, 32'h00000001, 32'h00000000, F_NONE});
        vecs.push_back('{"sub_x_sub",    32'h00000001, 32'h00000001, 32'h00000000, F_UNF});
        vecs.push_back('{"sub_x_2",      32'h00400000, 32'h40000000, 32'h00000000, F_UNF});
        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].f);
            wait_done(seen, lat);
            n_checks++;
            if (!seen || lat != 3) begin
                n_errors++;
                $display("FAIL %s latency: seen=%0d cycles=%0d, need done after 3", vecs[i].name, seen, lat);
            end
            if (seen) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.product_o !== e.p || flags_now() !== e.f) begin
                    n_errors++;
                    $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                             e.name, bus.product_o, flags_now(), e.p, e.f);
                end
            end else begin
                sb.delete();
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        bit   seen;
        int   lat;
        bit   extra;
        issue("busy_2.5x4", 32'h40200000, 32'h40800000, 32'h41200000, F_NONE);
        // Start held high across the UNPACK and MULT edges with other operands
        bus.start_i = 1'b1;
        bus.a_i     = 32'h7F800000;
        bus.b_i     = 32'h3F800000;
        @(negedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(seen, lat);
        n_checks++;
        if (!seen || lat != 1) begin
            n_errors++;
            $display("FAIL busy_latency: seen=%0d cycles=%0d, need done 1 edge later", seen, lat);
        end
        if (seen) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.product_o !== e.p || flags_now() !== e.f) begin
                n_errors++;
                $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                         e.name, bus.product_o, flags_now(), e.p, e.f);
            end
        end else begin
            sb.delete();
        end
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_no_second_done: extra done=%b, need 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen;
        int   lat;
        issue("b2b_first", 32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE);
        wait_done(seen, lat);
        n_checks++;
        if (!seen || lat != 3) begin
            n_errors++;
            $display("FAIL b2b_first_latency: seen=%0d cycles=%0d, need 3", seen, lat);
        end
        if (seen) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.product_o !== e.p || flags_now() !== e.f) begin
                n_errors++;
                $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                         e.name, bus.product_o, flags_now(), e.p, e.f);
            end
        end else begin
            sb.delete();
        end
        // Second request raised during the done cycle
        bus.start_i = 1'b1;
        bus.a_i     = 32'hBFC00000;
        bus.b_i     = 32'h40000000;
        e.p = 32'hC0400000;
        e.f = F_NONE;
        e.name = "b2b_second";
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.product_o !== 32'h3F800000) begin
            n_errors++;
            $display("FAIL b2b_done_fall: done=%b product=%h, need 0/3f800000", bus.done_o, bus.product_o);
        end
        wait_done(seen, lat);
        n_checks++;
        if (!seen || lat != 3) begin
            n_errors++;
            $display("FAIL b2b_second_latency: seen=%0d cycles=%0d, need 3", seen, lat);
        end
        if (seen) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.product_o !== e.p || flags_now() !== e.f) begin
                n_errors++;
                $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                         e.name, bus.product_o, flags_now(), e.p, e.f);
            end
        end else begin
            sb.delete();
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   seen;
        int   lat;
        bit   extra;
        // Leave non-zero outputs behind so the asynchronous clear is visible
        issue("pre_abort_ninf", 32'hFF800000, 32'h3F800000, 32'hFFFFFFFF, F_INF);
        wait_done(seen, lat);
        n_checks++;
        if (seen) begin
            e = sb.pop_front();
            if (bus.product_o !== e.p || flags_now() !== e.f) begin
                n_errors++;
                $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                         e.name, bus.product_o, flags_now(), e.p, e.f);
            end
        end else begin
            n_errors++;
            sb.delete();
            $display("FAIL pre_abort_done: seen=0, need 1");
        end
        issue("aborted", 32'h40200000, 32'h40800000, 32'h41200000, F_NONE);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.product_o !== 32'h0 || bus.done_o !== 1'b0 || flags_now() !== F_NONE) begin
            n_errors++;
            $display("FAIL abort_async_clear: product=%h done=%b flags=%b, need 00000000/0/0000",
                     bus.product_o, bus.done_o, flags_now());
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.product_o !== 32'h0) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_done: activity=%b, need 0", extra);
        end
        issue("post_abort_3.02x4", 32'h404147AE, 32'h40800000, 32'h414147AE, F_NONE);
        wait_done(seen, lat);
        n_checks++;
        if (!seen || lat != 3) begin
            n_errors++;
            sb.delete();
            $display("FAIL post_abort_latency: seen=%0d cycles=%0d, need 3", seen, lat);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.product_o !== e.p || flags_now() !== e.f) begin
                n_errors++;
                $display("FAIL %s result: product=%h flags=%b, need %h/%b",
                         e.name, bus.product_o, flags_now(), e.p, e.f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end
endmodule
